// File: rtl/match_pkg.sv
// match_pkg: state encoding, winner codes and counter sizing shared by match_ctrl.
package match_pkg;
   typedef enum logic [3:0] {
      IDLE, CLEAR, ROUND_START, PLAY, SETTLE, AWARD, CHECK, INTER, MATCH_OVER
   } state_t;
   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   // 3-bit debug codes; AWARD and CHECK share a code as they are back-to-back single cycles
   function automatic logic [2:0] dbg_code(input state_t s);
      logic [2:0] c;
      case (s)
         CLEAR:       c = 3'd1;
         ROUND_START: c = 3'd2;
         PLAY:        c = 3'd3;
         SETTLE:      c = 3'd4;
         AWARD:       c = 3'd5;
         CHECK:       c = 3'd5;
         INTER:       c = 3'd6;
         MATCH_OVER:  c = 3'd7;
         default:     c = 3'd0;
      endcase
      return c;
   endfunction
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a > b ? a : b;
      m = m > c ? m : c;
      return m > 1 ? $clog2(m) : 1;
   endfunction
endpackage

// File: rtl/cycle_counter.sv
// cycle_counter: loadable down-counter that stops at zero; done is high while the count is zero.
module cycle_counter #(
   parameter int W = 4
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         done
);
   logic [W-1:0] cnt;
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en && cnt != '0) cnt <= cnt - 1'b1;
   end
   assign done = cnt == '0;
endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: round/match sequencer driving the score counter from player-death events.
// Define MATCH_CTRL_TIMEOUT_EN to end idle rounds as a draw after ROUND_CYCLES.
module match_ctrl
   import match_pkg::*;
#(
   parameter logic [7:0] WIN_SCORE     = 8'h05,
   parameter int         SETTLE_CYCLES = 16,
   parameter int         INTER_CYCLES  = 1024,
   parameter int         ROUND_CYCLES  = 2**20
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       start,
   input  logic       p1_dead,
   input  logic       p2_dead,
   input  logic [7:0] p1score,
   input  logic [7:0] p2score,
   output logic       p1gain,
   output logic       p2gain,
   output logic       score_clr,
   output logic       round_reset,
   output logic       round_active,
   output logic [1:0] winner,
   output logic [2:0] state_dbg
);
   localparam int CW = cnt_width(SETTLE_CYCLES, INTER_CYCLES, ROUND_CYCLES);
   state_t state, nxt;
   logic d1, d2, d1_nx, d2_nx, sampling;
   logic cnt_load, cnt_en, cnt_done;
   logic [CW-1:0] cnt_val;
   logic p1gain_nx, p2gain_nx, score_clr_nx, round_reset_nx, round_active_nx;
   logic [1:0] winner_nx;
   logic [2:0] dbg_nx;

   cycle_counter #(.W(CW)) u_cnt (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .load    (cnt_load),
      .en      (cnt_en),
      .load_val(cnt_val),
      .done    (cnt_done)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= IDLE;
         d1           <= 1'b0;
         d2           <= 1'b0;
         p1gain       <= 1'b0;
         p2gain       <= 1'b0;
         score_clr    <= 1'b0;
         round_reset  <= 1'b0;
         round_active <= 1'b0;
         winner       <= WIN_NONE;
         state_dbg    <= 3'd0;
      end else begin
         state        <= nxt;
         d1           <= d1_nx;
         d2           <= d2_nx;
         p1gain       <= p1gain_nx;
         p2gain       <= p2gain_nx;
         score_clr    <= score_clr_nx;
         round_reset  <= round_reset_nx;
         round_active <= round_active_nx;
         winner       <= winner_nx;
         state_dbg    <= dbg_nx;
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:        if (start) nxt = CLEAR;
         CLEAR:       nxt = ROUND_START;
         ROUND_START: nxt = PLAY;
`ifdef MATCH_CTRL_TIMEOUT_EN
         PLAY:        nxt = (p1_dead | p2_dead) ? SETTLE : cnt_done ? AWARD : PLAY;
`else
         PLAY:        if (p1_dead | p2_dead) nxt = SETTLE;
`endif
         SETTLE:      if (cnt_done) nxt = AWARD;
         AWARD:       nxt = CHECK;
         CHECK:       nxt = (p1score >= WIN_SCORE || p2score >= WIN_SCORE) ? MATCH_OVER : INTER;
         INTER:       if (cnt_done) nxt = ROUND_START;
         MATCH_OVER:  if (start) nxt = CLEAR;
         default:     nxt = IDLE;
      endcase
   end

   // outputs are decoded from the next state so the registered copies line up with it
   always_comb begin
      sampling        = state == PLAY || state == SETTLE;
      d1_nx           = state == ROUND_START ? 1'b0 : d1 | (sampling & p1_dead);
      d2_nx           = state == ROUND_START ? 1'b0 : d2 | (sampling & p2_dead);
      p1gain_nx       = nxt == AWARD && d2_nx && !d1_nx;
      p2gain_nx       = nxt == AWARD && d1_nx && !d2_nx;
      score_clr_nx    = nxt == CLEAR;
      round_reset_nx  = nxt == ROUND_START;
      round_active_nx = nxt == PLAY || nxt == SETTLE;
      winner_nx       = nxt == CLEAR ? WIN_NONE :
                        (state == CHECK && nxt == MATCH_OVER) ? (p1score >= WIN_SCORE ? WIN_P1 : WIN_P2) :
                        winner;
      dbg_nx          = dbg_code(nxt);
      cnt_val         = nxt == SETTLE ? CW'(SETTLE_CYCLES - 1) :
                        nxt == INTER  ? CW'(INTER_CYCLES - 1)  : CW'(ROUND_CYCLES - 1);
`ifdef MATCH_CTRL_TIMEOUT_EN
      cnt_load        = (state == PLAY && nxt == SETTLE) || (state == CHECK && nxt == INTER) ||
                        (state == ROUND_START);
      cnt_en          = state == SETTLE || state == INTER || state == PLAY;
`else
      cnt_load        = (state == PLAY && nxt == SETTLE) || (state == CHECK && nxt == INTER);
      cnt_en          = state == SETTLE || state == INTER;
`endif
   end
endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: directed rounds with a score counter model and a pulse scoreboard.
module tb_match_ctrl;
   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       start = 1'b0;
   logic       p1_dead = 1'b0;
   logic       p2_dead = 1'b0;
   logic [7:0] p1score, p2score;
   logic       p1gain, p2gain, score_clr, round_reset, round_active;
   logic [1:0] winner;
   logic [2:0] state_dbg;
   int checks = 0;
   int errors = 0;
   typedef struct {
      string      tag;
      logic [3:0] v;
   } exp_t;
   exp_t exp_q[$];

   match_ctrl #(
      .WIN_SCORE    (8'h02),
      .SETTLE_CYCLES(4),
      .INTER_CYCLES (8),
      .ROUND_CYCLES (16)
   ) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .start       (start),
      .p1_dead     (p1_dead),
      .p2_dead     (p2_dead),
      .p1score     (p1score),
      .p2score     (p2score),
      .p1gain      (p1gain),
      .p2gain      (p2gain),
      .score_clr   (score_clr),
      .round_reset (round_reset),
      .round_active(round_active),
      .winner      (winner),
      .state_dbg   (state_dbg)
   );

   always #5 Clk = ~Clk;

   function automatic logic [7:0] bcd_inc(input logic [7:0] s);
      return s[3:0] == 4'd9 ? {s[7:4] + 4'd1, 4'd0} : {s[7:4], s[3:0] + 4'd1};
   endfunction

   // score counter model: synchronous clear, BCD +1 per gain pulse
   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         p1score <= 8'h00;
         p2score <= 8'h00;
      end else if (score_clr) begin
         p1score <= 8'h00;
         p2score <= 8'h00;
      end else begin
         if (p1gain) p1score <= bcd_inc(p1score);
         if (p2gain) p2score <= bcd_inc(p2score);
      end
   end

   // every pulse cycle must match the next expected pulse pattern {p1gain,p2gain,score_clr,round_reset}
   always @(negedge Clk) begin
      if (Reset_n && (p1gain | p2gain | score_clr | round_reset)) begin
         exp_t e;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_pulse: observed %b expected none", {p1gain, p2gain, score_clr, round_reset});
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert ({p1gain, p2gain, score_clr, round_reset} === e.v) else begin
               errors++;
               $error("FAIL %s: observed %b expected %b", e.tag, {p1gain, p2gain, score_clr, round_reset}, e.v);
            end
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [3:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      exp_q.push_back(e);
   endtask

   // from the first SETTLE cycle: three more SETTLE cycles, then AWARD
   task automatic settle_award(input string tag, input logic g1, input logic g2);
      step(3);
      chk({tag, "_settle_last"}, 16'(state_dbg), 16'd4);
      chk({tag, "_no_early_gain"}, 16'({p1gain, p2gain}), 16'd0);
      step();
      chk({tag, "_award_dbg"}, 16'(state_dbg), 16'd5);
      chk({tag, "_gains"}, 16'({p1gain, p2gain}), 16'({g1, g2}));
   endtask

   // from AWARD: CHECK, eight INTER cycles, ROUND_START, PLAY
   task automatic to_next_round(input string tag);
      step();
      chk({tag, "_check_dbg"}, 16'(state_dbg), 16'd5);
      step();
      chk({tag, "_inter_first"}, 16'(state_dbg), 16'd6);
      step(7);
      chk({tag, "_inter_last"}, 16'({round_reset, state_dbg}), 16'd6);
      step();
      chk({tag, "_round_reset"}, 16'({round_reset, state_dbg}), 16'h000a);
      step();
      chk({tag, "_play"}, 16'({round_active, state_dbg}), 16'h000b);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      step(2);
      chk("reset_outputs", 16'({p1gain, p2gain, score_clr, round_reset, round_active, winner, state_dbg}), 16'd0);
      Reset_n = 1'b1;
      step();
      chk("idle_stays", 16'(state_dbg), 16'd0);
      // match start
      start = 1'b1;
      push("start_clr", 4'b0010);
      push("start_rr", 4'b0001);
      step();
      start = 1'b0;
      chk("c1_score_clr", 16'({score_clr, state_dbg}), 16'h0009);
      step();
      chk("c2_round_reset", 16'({round_reset, round_active}), 16'h0002);
      step();
      chk("c3_active", 16'({round_active, state_dbg}), 16'h000b);
      // round 1: P2 dies, P1 scores
      p2_dead = 1'b1;
      push("r1_p1gain", 4'b1000);
      push("r1_rr", 4'b0001);
      step();
      p2_dead = 1'b0;
      chk("r1_settle", 16'({round_active, state_dbg}), 16'h000c);
      settle_award("r1", 1'b1, 1'b0);
      to_next_round("r1");
      chk("r1_p1score", 16'(p1score), 16'h0001);
      // round 2: P1 dies, P2 dies two cycles later; start is ignored in PLAY
      start = 1'b1;
      p1_dead = 1'b1;
      push("r2_rr", 4'b0001);
      step();
      start = 1'b0;
      p1_dead = 1'b0;
      chk("r2_settle", 16'(state_dbg), 16'd4);
      step();
      p2_dead = 1'b1;
      step();
      p2_dead = 1'b0;
      step(2);
      chk("r2_award_dbg", 16'(state_dbg), 16'd5);
      chk("r2_draw_gains", 16'({p1gain, p2gain}), 16'd0);
      to_next_round("r2");
      chk("r2_scores", 16'({p1score, p2score}), 16'h0100);
      // round 3: simultaneous deaths still settle, result is a draw
      p1_dead = 1'b1;
      p2_dead = 1'b1;
      push("r3_rr", 4'b0001);
      step();
      p1_dead = 1'b0;
      p2_dead = 1'b0;
      chk("r3_settle", 16'(state_dbg), 16'd4);
      settle_award("r3", 1'b0, 1'b0);
      to_next_round("r3");
      chk("r3_scores", 16'({p1score, p2score}), 16'h0100);
      // round 4: P1 reaches the win score
      p2_dead = 1'b1;
      push("r4_p1gain", 4'b1000);
      step();
      p2_dead = 1'b0;
      settle_award("r4", 1'b1, 1'b0);
      step();
      chk("r4_check_score", 16'({state_dbg, p1score}), 16'h0502);
      step();
      chk("r4_match_over", 16'({round_active, winner, state_dbg}), 16'h000f);
      p2_dead = 1'b1;
      step();
      p2_dead = 1'b0;
      step(2);
      chk("r4_winner_held", 16'({winner, state_dbg}), 16'h000f);
      start = 1'b1;
      push("restart_clr", 4'b0010);
      push("restart_rr", 4'b0001);
      step();
      start = 1'b0;
      chk("restart_winner_clr", 16'({winner, score_clr}), 16'h0001);
      step();
      chk("restart_scores_zero", 16'({p1score, p2score}), 16'h0000);
      step();
      chk("restart_play", 16'(state_dbg), 16'd3);
      // round 5: reset during SETTLE aborts without an award
      p1_dead = 1'b1;
      step();
      p1_dead = 1'b0;
      step(2);
      chk("r5_settle", 16'(state_dbg), 16'd4);
      Reset_n = 1'b0;
      #1;
      chk("r5_reset_now", 16'({p1gain, p2gain, score_clr, round_reset, round_active, winner, state_dbg}), 16'd0);
      step(2);
      Reset_n = 1'b1;
      step(8);
      chk("r5_after_reset", 16'({p1gain, p2gain, score_clr, round_reset, round_active, winner, state_dbg}), 16'd0);
`ifdef MATCH_CTRL_TIMEOUT_EN
      // idle round times out as a draw after 16 PLAY cycles
      start = 1'b1;
      push("to_clr", 4'b0010);
      push("to_rr", 4'b0001);
      step();
      start = 1'b0;
      step(2);
      chk("to_play", 16'(state_dbg), 16'd3);
      step(15);
      chk("to_play_last", 16'(state_dbg), 16'd3);
      step();
      chk("to_award", 16'({p1gain, p2gain, state_dbg}), 16'd5);
`endif
      chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
